lop_norm_shifter: RTL and testbench

//  Consumer end of the leading-one-position (LOP) interface. Takes {addr, data, one_position,

---
 rtl/lop_norm_pkg.sv | 8 +
 rtl/lop_norm_shifter_if.sv | 29 ++
 rtl/lop_consist_check.sv | 19 +
 rtl/lop_norm_shifter.sv | 61 ++++++
 tb/tb_lop_norm_shifter.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/lop_norm_pkg.sv
// lop_norm_pkg: shared FSM state type, default step size and step-clamp helper.
package lop_norm_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;
  localparam int STEP_DEF = 4;
  function automatic int step_min(int step, int rem);
    return rem < step ? rem : step;
  endfunction
endpackage

// File: rtl/lop_norm_shifter_if.sv
// lop_norm_shifter_if: upstream LOP word and downstream normalised result, valid/ready on both sides.
//  slave  : normaliser view (consumes i_*, drives o_*)
//  master : environment view (drives i_*, consumes o_*)
interface lop_norm_shifter_if #(
  parameter int SIZE_DATA = 24,
  parameter int SIZE_LOP  = 5
);
  logic                 i_valid;
  logic                 o_ready;
  logic [SIZE_DATA-1:0] i_addr;
  logic [SIZE_DATA-1:0] i_data;
  logic [SIZE_LOP-1:0]  i_one_position;
  logic                 i_zero_flag;
  logic                 o_valid;
  logic                 i_ready;
  logic [SIZE_DATA-1:0] o_addr;
  logic [SIZE_DATA-1:0] o_norm_data;
  logic [SIZE_LOP-1:0]  o_shift_amt;
  logic                 o_zero_flag;
  logic                 o_err;
  modport slave (
    input  i_valid, i_addr, i_data, i_one_position, i_zero_flag, i_ready,
    output o_ready, o_valid, o_addr, o_norm_data, o_shift_amt, o_zero_flag, o_err
  );
  modport master (
    output i_valid, i_addr, i_data, i_one_position, i_zero_flag, i_ready,
    input  o_ready, o_valid, o_addr, o_norm_data, o_shift_amt, o_zero_flag, o_err
  );
endinterface

// File: rtl/lop_consist_check.sv
// lop_consist_check: checks a leading-one position against its data and derives the shift needed.
//  data, pos, zero_flag in; err (position inconsistent) and rem (left shift still required) out.
module lop_consist_check #(
  parameter int SIZE_DATA = 24,
  parameter int SIZE_LOP  = 5
) (
  input  logic [SIZE_DATA-1:0] data,
  input  logic [SIZE_LOP-1:0]  pos,
  input  logic                 zero_flag,
  output logic                 err,
  output logic [SIZE_LOP-1:0]  rem
);
  logic [SIZE_DATA-1:0] sh;
  // After shifting right by pos, a consistent word is exactly 1. Out-of-range
  // positions and all-zero data both leave bit 0 clear, so they fail too.
  assign sh  = data >> pos;
  assign err = !zero_flag && (!sh[0] || (|sh[SIZE_DATA-1:1]));
  assign rem = (zero_flag || err) ? '0 : SIZE_LOP'(SIZE_DATA-1) - pos;
endmodule

// File: rtl/lop_norm_shifter.sv
// lop_norm_shifter: left-normalises a word to its leading one, STEP bits per cycle, reporting the shift.
//  i_clk, i_rst : clock and synchronous active-high reset
//  bus          : slave side of lop_norm_shifter_if (input word + result handshakes)
module lop_norm_shifter
  import lop_norm_pkg::*;
#(
  parameter int SIZE_DATA = 24,
  parameter int SIZE_LOP  = 5,
  parameter int STEP      = STEP_DEF
) (
  input logic i_clk,
  input logic i_rst,
  lop_norm_shifter_if.slave bus
);
  state_t              state;
  logic [SIZE_LOP-1:0] rem_r;
  logic [SIZE_LOP-1:0] rem_in;
  logic [SIZE_LOP-1:0] st;
  logic                err_in;
  lop_consist_check #(.SIZE_DATA(SIZE_DATA), .SIZE_LOP(SIZE_LOP)) u_check (
    .data      (bus.i_data),
    .pos       (bus.i_one_position),
    .zero_flag (bus.i_zero_flag),
    .err       (err_in),
    .rem       (rem_in)
  );
  assign st          = SIZE_LOP'(step_min(STEP, int'(rem_r)));
  assign bus.o_ready = state == IDLE;
  assign bus.o_valid = state == HOLD;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state           <= IDLE;
      rem_r           <= '0;
      bus.o_addr      <= '0;
      bus.o_norm_data <= '0;
      bus.o_shift_amt <= '0;
      bus.o_zero_flag <= 1'b0;
      bus.o_err       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.i_valid) begin
          bus.o_addr      <= bus.i_addr;
          bus.o_norm_data <= bus.i_zero_flag ? '0 : bus.i_data;
          bus.o_shift_amt <= '0;
          bus.o_zero_flag <= bus.i_zero_flag;
          bus.o_err       <= err_in;
          rem_r           <= rem_in;
          state           <= rem_in != '0 ? SHIFT : HOLD;
        end
        SHIFT: begin
          bus.o_norm_data <= bus.o_norm_data << st;
          bus.o_shift_amt <= bus.o_shift_amt + st;
          rem_r           <= rem_r - st;
          state           <= rem_r <= SIZE_LOP'(STEP) ? HOLD : SHIFT;
        end
        HOLD: state <= bus.i_ready ? IDLE : HOLD;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lop_norm_shifter.sv
// tb_lop_norm_shifter: scoreboard bench for lop_norm_shifter with directed and random words.
module tb_lop_norm_shifter;
  typedef struct {
    logic [23:0] addr;
    logic [23:0] norm;
    logic [4:0]  shift;
    logic        zero;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  exp_t q[$];
  int   nvec = 0;
  int   nerr = 0;
  int   cyc  = 0;
  int   mode = 0;
  bit   seen = 1'b0;
  lop_norm_shifter_if bus ();
  lop_norm_shifter dut (.i_clk(clk), .i_rst(rst), .bus(bus));
  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  function automatic exp_t model(input logic [23:0] a, input logic [23:0] d, input logic [4:0] p, input logic z);
    exp_t e;
    logic [23:0] sh;
    sh = d >> p;
    e.addr = a;
    e.zero = z;
    e.err = !z && (sh != 24'd1);
    e.norm = z ? 24'd0 : e.err ? d : d << (5'd23 - p);
    e.shift = (z || e.err) ? 5'd0 : 5'd23 - p;
    e.lat = 1 + (int'(e.shift) + 3) / 4;
    e.acc = 0;
    return e;
  endfunction
  task automatic send(input logic [23:0] a, input logic [23:0] d, input logic [4:0] p, input logic z,
                      input logic [23:0] en, input logic [4:0] es, input logic ee, input int el);
    exp_t e;
    bus.i_valid = 1'b1;
    bus.i_addr = a;
    bus.i_data = d;
    bus.i_one_position = p;
    bus.i_zero_flag = z;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.o_ready) begin
        e = '{addr: a, norm: en, shift: es, zero: z, err: ee, lat: el, acc: cyc};
        q.push_back(e);
        @(posedge clk);
        #1;
        bus.i_valid = 1'b0;
        return;
      end
    end
    chk("accept_timeout", 32'(bus.o_ready), 1);
    bus.i_valid = 1'b0;
  endtask
  task automatic send_model(input logic [23:0] a, input logic [23:0] d, input logic [4:0] p, input logic z);
    exp_t e;
    e = model(a, d, p, z);
    send(a, d, p, z, e.norm, e.shift, e.err, e.lat);
  endtask
  initial forever begin
    @(negedge clk);
    if (!rst && bus.o_valid) begin
      if (q.size() == 0) chk("spurious_valid", 32'(bus.o_valid), 0);
      else begin
        if (!seen) begin
          chk("latency", 32'(cyc - q[0].acc), 32'(q[0].lat));
          seen = 1'b1;
        end
        chk("addr", 32'(bus.o_addr), 32'(q[0].addr));
        chk("norm", 32'(bus.o_norm_data), 32'(q[0].norm));
        chk("shift", 32'(bus.o_shift_amt), 32'(q[0].shift));
        chk("zero", 32'(bus.o_zero_flag), 32'(q[0].zero));
        chk("err", 32'(bus.o_err), 32'(q[0].err));
        if (bus.i_ready) begin
          void'(q.pop_front());
          seen = 1'b0;
        end
      end
    end
  end
  initial forever begin
    @(posedge clk);
    #1;
    if (mode == 1) bus.i_ready = 1'($urandom_range(0, 1));
    else if (mode == 0) bus.i_ready = 1'b1;
  end
  task automatic chk_reset(input string tag);
    chk({tag, "_valid"}, 32'(bus.o_valid), 0);
    chk({tag, "_ready"}, 32'(bus.o_ready), 1);
    chk({tag, "_addr"}, 32'(bus.o_addr), 0);
    chk({tag, "_norm"}, 32'(bus.o_norm_data), 0);
    chk({tag, "_shift"}, 32'(bus.o_shift_amt), 0);
    chk({tag, "_zero"}, 32'(bus.o_zero_flag), 0);
    chk({tag, "_err"}, 32'(bus.o_err), 0);
  endtask
  initial begin
    logic [23:0] d;
    logic [4:0]  p;
    logic        z;
    bus.i_valid = 1'b0;
    bus.i_addr = '0;
    bus.i_data = '0;
    bus.i_one_position = '0;
    bus.i_zero_flag = 1'b0;
    bus.i_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    send(24'h000003, 24'h00F0A5, 5'd15, 1'b0, 24'hF0A500, 5'd8, 1'b0, 3);
    send(24'h000004, 24'h000000, 5'd7, 1'b1, 24'h000000, 5'd0, 1'b0, 1);
    send(24'h000005, 24'h010000, 5'd12, 1'b0, 24'h010000, 5'd0, 1'b1, 1);
    send(24'h000006, 24'h010000, 5'd30, 1'b0, 24'h010000, 5'd0, 1'b1, 1);
    send(24'h000007, 24'h000000, 5'd0, 1'b0, 24'h000000, 5'd0, 1'b1, 1);
    for (int k = 0; k < 24; k++)
      send(24'(k), 24'd1 << k, 5'(k), 1'b0, 24'h800000, 5'(23 - k), 1'b0, 1 + (23 - k + 3) / 4);
    send(24'h0000AA, 24'h000001, 5'd0, 1'b0, 24'h800000, 5'd23, 1'b0, 7);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset("mid_reset");
    q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    mode = 2;
    bus.i_ready = 1'b0;
    send(24'h0000A1, 24'h800000, 5'd23, 1'b0, 24'h800000, 5'd0, 1'b0, 1);
    for (int i = 0; i < 5; i++) begin
      bus.i_valid = 1'b1;
      bus.i_addr = 24'h0000EE;
      bus.i_data = 24'h000001;
      bus.i_one_position = 5'd0;
      @(negedge clk);
      chk("hold_ready", 32'(bus.o_ready), 0);
      chk("hold_valid", 32'(bus.o_valid), 1);
      @(posedge clk);
      #1;
    end
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("idle_after_hold", 32'(bus.o_ready), 1);
    @(posedge clk);
    #1;
    mode = 0;
    send(24'h0000B2, 24'h000010, 5'd4, 1'b0, 24'h800000, 5'd19, 1'b0, 6);
    mode = 1;
    for (int n = 0; n < 1000; n++) begin
      p = 5'($urandom_range(0, 23));
      d = (24'd1 << p) | (24'($urandom) & ((24'd1 << p) - 24'd1));
      z = 1'b0;
      if (n % 16 == 5) z = 1'b1;
      if (n % 13 == 7) begin
        d = 24'($urandom);
        p = 5'($urandom_range(0, 31));
      end
      send_model(24'(n + 24'h100000), d, p, z);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    for (int i = 0; i < 2000 && q.size() != 0; i++) @(posedge clk);
    chk("drain", 32'(q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
